// File: rtl/mul_seq_multi_if.sv
// Handshake and payload bundle for the iterative multiplier.
// The master drives operations in and consumes results; the slave is the multiplier.
interface mul_seq_multi_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 5
);
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [1:0]         in_op;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_result;
  logic [2*WIDTH-1:0] out_prod;
  logic [TAG_W-1:0]   out_tag;

  modport master (
    output flush, in_valid, in_op, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_prod, out_tag
  );

  modport slave (
    input  flush, in_valid, in_op, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_prod, out_tag
  );
endinterface

// File: rtl/mul_seq_multi.sv
// Iterative RV32M/RV64M multiplier: sign-magnitude operands, carry-save accumulation of
// PP_PER_CYC partial products per cycle. Define MUL_EARLY_OUT_EN to skip all-zero upper multiplier chunks.
module mul_seq_multi #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned PP_PER_CYC = 8,
  parameter int unsigned TAG_W      = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  mul_seq_multi_if.slave bus
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned N     = WIDTH / PP_PER_CYC;
  localparam int unsigned CNT_W = $clog2(N + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] b_rem;
  logic [PW-1:0]    a_sh, sum_q, carry_q, sum_nxt, carry_nxt;
  logic             sgn_q;
  logic [1:0]       op_q;
  logic [TAG_W-1:0] tag_q;

  logic             out_valid_q;
  logic [WIDTH-1:0] out_result_q;
  logic [PW-1:0]    out_prod_q;
  logic [TAG_W-1:0] out_tag_q;

  logic             in_ready_c, accept_c, a_neg_c, b_neg_c, step_c, resolve_c;
  logic [WIDTH-1:0] a_mag_c, b_mag_c;
  logic [PW-1:0]    prod_mag_c, prod_c;

  // Flush beats handoff beats accept: nothing is taken while flush is high.
  assign in_ready_c = !bus.flush &&
                      ((state == S_IDLE) || ((state == S_DONE) && bus.out_ready));
  assign accept_c   = bus.in_valid && in_ready_c;

  assign a_neg_c = ((bus.in_op == OP_MULH) || (bus.in_op == OP_MULHSU)) && bus.in_a[WIDTH-1];
  assign b_neg_c = (bus.in_op == OP_MULH) && bus.in_b[WIDTH-1];
  assign a_mag_c = a_neg_c ? (~bus.in_a + WIDTH'(1)) : bus.in_a;
  assign b_mag_c = b_neg_c ? (~bus.in_b + WIDTH'(1)) : bus.in_b;

  // cnt counts absorbed chunks; cnt==N is the resolve cycle that enters DONE.
  assign step_c    = (state == S_RUN) && (cnt != CNT_W'(N));
  assign resolve_c = (state == S_RUN) && (cnt == CNT_W'(N));

`ifdef MUL_EARLY_OUT_EN
  assign cnt_nxt = ((b_rem >> PP_PER_CYC) == '0) ? CNT_W'(N) : (cnt + CNT_W'(1));
`else
  assign cnt_nxt = cnt + CNT_W'(1);
`endif

  // 3:2 compression of this cycle's partial products into the sum/carry pair.
  always_comb begin : csa
    logic [PW-1:0] pp;
    logic [PW-1:0] t;
    sum_nxt   = sum_q;
    carry_nxt = carry_q;
    pp        = '0;
    t         = '0;
    for (int j = 0; j < int'(PP_PER_CYC); j++) begin
      pp        = b_rem[j] ? (a_sh << j) : '0;
      t         = sum_nxt ^ carry_nxt ^ pp;
      carry_nxt = ((sum_nxt & carry_nxt) | (sum_nxt & pp) | (carry_nxt & pp)) << 1;
      sum_nxt   = t;
    end
  end

  assign prod_mag_c = sum_q + carry_q;
  assign prod_c     = sgn_q ? (~prod_mag_c + PW'(1)) : prod_mag_c;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept_c) state_nxt = S_RUN;
      S_RUN:   if (resolve_c) state_nxt = S_DONE;
      S_DONE:  if (bus.out_ready) state_nxt = accept_c ? S_RUN : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (bus.flush) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      b_rem        <= '0;
      a_sh         <= '0;
      sum_q        <= '0;
      carry_q      <= '0;
      sgn_q        <= 1'b0;
      op_q         <= '0;
      tag_q        <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_prod_q   <= '0;
      out_tag_q    <= '0;
    end else begin
      out_valid_q <= (state_nxt == S_DONE);
      if (accept_c) begin
        cnt     <= '0;
        a_sh    <= PW'(a_mag_c);
        b_rem   <= b_mag_c;
        sum_q   <= '0;
        carry_q <= '0;
        sgn_q   <= a_neg_c ^ b_neg_c;
        op_q    <= bus.in_op;
        tag_q   <= bus.in_tag;
      end else if (step_c) begin
        cnt     <= cnt_nxt;
        a_sh    <= a_sh << PP_PER_CYC;
        b_rem   <= b_rem >> PP_PER_CYC;
        sum_q   <= sum_nxt;
        carry_q <= carry_nxt;
      end
      if (resolve_c && !bus.flush) begin
        out_prod_q   <= prod_c;
        out_result_q <= (op_q == OP_MUL) ? prod_c[WIDTH-1:0] : prod_c[PW-1:WIDTH];
        out_tag_q    <= tag_q;
      end
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;
  assign bus.out_prod   = out_prod_q;
  assign bus.out_tag    = out_tag_q;

endmodule

// File: tb/tb_mul_seq_multi.sv
// Directed bench for mul_seq_multi: 32/8 instance for modes, handshake, flush and reset,
// plus a 64/8 instance for the wide-operand latency case.
module tb_mul_seq_multi;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  mul_seq_multi_if #(.WIDTH(32), .TAG_W(5)) b32 ();
  mul_seq_multi_if #(.WIDTH(64), .TAG_W(5)) b64 ();

  mul_seq_multi #(.WIDTH(32), .PP_PER_CYC(8), .TAG_W(5)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));
  mul_seq_multi #(.WIDTH(64), .PP_PER_CYC(8), .TAG_W(5)) dut64 (.clk(clk), .rst_n(rst_n), .bus(b64));

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected accept-to-valid edges for a multiplier magnitude.
  function automatic int exp_lat(input logic [63:0] bmag, input int w, input int p);
`ifdef MUL_EARLY_OUT_EN
    int hi = 0;
    for (int k = 0; k < w / p; k++)
      if ((bmag >> (k * p)) != 64'd0) hi = k;
    return hi + 2;
`else
    return w / p + 1;
`endif
  endfunction

  task automatic send32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag);
    logic rdy;
    int   guard = 0;
    b32.in_op = op; b32.in_a = a; b32.in_b = b; b32.in_tag = tag; b32.in_valid = 1'b1;
    do begin
      rdy = b32.in_ready;
      tick();
      guard++;
    end while (!rdy && guard < 50);
    if (!rdy) check("accept_timeout", 0, 1);
    b32.in_valid = 1'b0;
    b32.in_a = 32'hDEAD_BEEF;
    b32.in_b = 32'hFFFF_FFFF;
  endtask

  task automatic wait32(output int cyc);
    cyc = 0;
    while (!b32.out_valid && cyc < 50) begin
      tick();
      cyc++;
    end
  endtask

  task automatic op32(input string name, input logic [1:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] tag, input logic [63:0] prod);
    int c;
    logic [31:0] bmag;
    bmag = (op == 2'b01 && b[31]) ? (~b + 32'd1) : b;
    b32.out_ready = 1'b1;
    send32(op, a, b, tag);
    wait32(c);
    check({name, "_lat"}, 128'(c), 128'(exp_lat(64'(bmag), 32, 8)));
    check({name, "_res"}, 128'(b32.out_result), 128'((op == 2'b00) ? prod[31:0] : prod[63:32]));
    check({name, "_prod"}, 128'(b32.out_prod), 128'(prod));
    check({name, "_tag"}, 128'(b32.out_tag), 128'(tag));
    tick();
    check({name, "_drop"}, 128'(b32.out_valid), 128'(0));
  endtask

  task automatic op64(input string name, input logic [1:0] op, input logic [63:0] a,
                      input logic [63:0] b, input logic [4:0] tag, input logic [127:0] prod);
    int c = 0;
    b64.out_ready = 1'b1;
    b64.in_op = op; b64.in_a = a; b64.in_b = b; b64.in_tag = tag; b64.in_valid = 1'b1;
    check({name, "_in_ready"}, 128'(b64.in_ready), 128'(1));
    tick();
    b64.in_valid = 1'b0;
    while (!b64.out_valid && c < 50) begin
      tick();
      c++;
    end
    check({name, "_lat"}, 128'(c), 128'(exp_lat(b, 64, 8)));
    check({name, "_res"}, 128'(b64.out_result), 128'((op == 2'b00) ? prod[63:0] : prod[127:64]));
    check({name, "_prod"}, b64.out_prod, prod);
    tick();
  endtask

  task automatic count_valid32(input int n, output int seen);
    seen = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (b32.out_valid) seen++;
    end
  endtask

  initial begin
    int c;
    int seen;
    b32.flush = 1'b0; b32.in_valid = 1'b0; b32.in_op = '0; b32.in_a = '0; b32.in_b = '0;
    b32.in_tag = '0; b32.out_ready = 1'b1;
    b64.flush = 1'b0; b64.in_valid = 1'b0; b64.in_op = '0; b64.in_a = '0; b64.in_b = '0;
    b64.in_tag = '0; b64.out_ready = 1'b1;

    #12;
    check("rst_in_ready", 128'(b32.in_ready), 128'(1));
    check("rst_out_valid", 128'(b32.out_valid), 128'(0));
    check("rst_result", 128'(b32.out_result), 128'(0));
    check("rst_prod", 128'(b32.out_prod), 128'(0));
    check("rst_tag", 128'(b32.out_tag), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    op32("mul_7x6",   2'b00, 32'd7,         32'd6,         5'd3,  64'd42);
    op32("mulh_min",  2'b01, 32'h8000_0000, 32'h8000_0000, 5'd10, 64'h4000_0000_0000_0000);
    op32("mulhsu_m1", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11, 64'hFFFF_FFFF_0000_0001);
    op32("mulhu_max", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12, 64'hFFFF_FFFE_0000_0001);
    op32("mul_neg",   2'b00, 32'hFFFF_FFFD, 32'd5,         5'd13, 64'h0000_0004_FFFF_FFF1);
    op32("mulh_neg",  2'b01, 32'hFFFF_FFFD, 32'd5,         5'd14, 64'hFFFF_FFFF_FFFF_FFF1);
    op32("mulh_pos",  2'b01, 32'h1234_5678, 32'h0000_0010, 5'd15, 64'h0000_0001_2345_6780);

    // Backpressure in DONE, then handoff and accept in the same cycle.
    b32.out_ready = 1'b0;
    send32(2'b00, 32'd9, 32'd9, 5'd7);
    wait32(c);
    check("bp_lat", 128'(c), 128'(exp_lat(64'd9, 32, 8)));
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_valid", 128'(b32.out_valid), 128'(1));
      check("bp_res", 128'(b32.out_result), 128'(81));
      check("bp_tag", 128'(b32.out_tag), 128'(7));
      check("bp_in_ready", 128'(b32.in_ready), 128'(0));
    end
    b32.in_op = 2'b00; b32.in_a = 32'h100; b32.in_b = 32'h100; b32.in_tag = 5'd9;
    b32.in_valid = 1'b1;
    b32.out_ready = 1'b1;
    #1;
    check("b2b_in_ready", 128'(b32.in_ready), 128'(1));
    tick();
    b32.in_valid = 1'b0;
    check("b2b_handoff", 128'(b32.out_valid), 128'(0));
    wait32(c);
    check("b2b_lat", 128'(c), 128'(exp_lat(64'h100, 32, 8)));
    check("b2b_res", 128'(b32.out_result), 128'(32'h1_0000));
    check("b2b_tag", 128'(b32.out_tag), 128'(9));
    tick();

    // Flush two cycles after accept discards the operation.
    send32(2'b00, 32'd3, 32'd4, 5'd1);
    tick();
    b32.flush = 1'b1;
    #1;
    check("flush_in_ready_lo", 128'(b32.in_ready), 128'(0));
    tick();
    b32.flush = 1'b0;
    #1;
    check("flush_in_ready_hi", 128'(b32.in_ready), 128'(1));
    check("flush_valid", 128'(b32.out_valid), 128'(0));
    count_valid32(8, seen);
    check("flush_no_result", 128'(seen), 128'(0));
    // Flush in IDLE blocks an offered operation.
    b32.flush = 1'b1; b32.in_valid = 1'b1; b32.in_a = 32'd5; b32.in_b = 32'd5;
    #1;
    check("flush_idle_ready", 128'(b32.in_ready), 128'(0));
    tick();
    b32.flush = 1'b0; b32.in_valid = 1'b0;
    count_valid32(8, seen);
    check("flush_idle_none", 128'(seen), 128'(0));
    op32("post_flush", 2'b00, 32'd11, 32'd13, 5'd2, 64'd143);

    // Asynchronous reset in the middle of RUN.
    send32(2'b00, 32'h1234_5678, 32'h0102_0304, 5'd6);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_in_ready", 128'(b32.in_ready), 128'(1));
    check("arst_valid", 128'(b32.out_valid), 128'(0));
    check("arst_result", 128'(b32.out_result), 128'(0));
    check("arst_prod", 128'(b32.out_prod), 128'(0));
    check("arst_tag", 128'(b32.out_tag), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    count_valid32(8, seen);
    check("arst_no_result", 128'(seen), 128'(0));
    op32("post_rst", 2'b00, 32'hFFFF_FFFF, 32'd2, 5'd8, 64'h0000_0001_FFFF_FFFE);

    // 64-bit instance: small multiplier exercises the early-out path when enabled.
    op64("w64_mul3", 2'b00, 64'h0000_0001_0000_0001, 64'd3, 5'd5,
         128'h0000_0000_0000_0000_0000_0003_0000_0003);
    op64("w64_mulhsu", 2'b10, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 5'd17,
         128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFA);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
